// File: rtl/bicubic_pkg.sv
// Shared types and default geometry for the bicubic window-fetch path.
package bicubic_pkg;

    localparam int IMG_W  = 100;
    localparam int PIX_W  = 8;
    localparam int ROM_AW = 14;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        OUT
    } fetch_state_t;

    // Byte 4*r+c is the pixel at window row r, column c.
    typedef logic [15:0][PIX_W-1:0] win_t;

endpackage

// File: rtl/bicubic_win_fetch_if.sv
// Request, ROM read and window hand-off signals of the window-fetch stage.
interface bicubic_win_fetch_if #(
    parameter int PIX_W  = bicubic_pkg::PIX_W,
    parameter int ROM_AW = bicubic_pkg::ROM_AW
);
    logic                   req_valid;
    logic                   req_ready;
    logic [4:0]             req_x;
    logic [4:0]             req_y;
    logic                   rom_ce;
    logic [ROM_AW-1:0]      rom_addr;
    logic [PIX_W-1:0]       rom_q;
    logic                   win_valid;
    logic                   win_ready;
    logic [16*PIX_W-1:0]    win_data;

    // master: requester, ROM and interpolator side; slave: the fetch unit
    modport master (
        output req_valid, req_x, req_y, rom_q, win_ready,
        input  req_ready, rom_ce, rom_addr, win_valid, win_data
    );

    modport slave (
        input  req_valid, req_x, req_y, rom_q, win_ready,
        output req_ready, rom_ce, rom_addr, win_valid, win_data
    );
endinterface

// File: rtl/bicubic_addr_gen.sv
// Border-clamped 4x4 neighbourhood address: (V0+row)*IMG_W + (H0+col), no multiplier.
module bicubic_addr_gen #(
    parameter int IMG_W  = bicubic_pkg::IMG_W,
    parameter int ROM_AW = bicubic_pkg::ROM_AW
) (
    input  logic [6:0]        h0,
    input  logic [6:0]        v0,
    input  logic [4:0]        sw,
    input  logic [4:0]        sh,
    input  logic [4:0]        x,
    input  logic [4:0]        y,
    input  logic [1:0]        c,
    input  logic [1:0]        r,
    output logic [ROM_AW-1:0] addr
);
    import bicubic_pkg::*;

    // base-1+off lies in -1..33, so 7-bit signed holds it before clamping to 0..lim-1
    function automatic logic [4:0] clamp_coord(input logic [4:0] base,
                                               input logic [1:0] off,
                                               input logic [4:0] lim);
        logic signed [6:0] pos;
        logic signed [6:0] hi;
        pos = $signed({2'b00, base}) + $signed({5'b00000, off}) - 7'sd1;
        hi  = $signed({2'b00, lim}) - 7'sd1;
        if (pos < 7'sd0)
            pos = 7'sd0;
        else if (pos > hi)
            pos = hi;
        return pos[4:0];
    endfunction

    // Constant pitch: one shifted add per set bit of IMG_W (100 -> 64+32+4).
    function automatic logic [ROM_AW-1:0] mul_pitch(input logic [7:0] v);
        logic [ROM_AW-1:0] acc;
        acc = '0;
        for (int i = 0; i < ROM_AW; i++) begin
            if (IMG_W[i])
                acc = acc + ({{(ROM_AW-8){1'b0}}, v} << i);
        end
        return acc;
    endfunction

    logic [4:0] col;
    logic [4:0] row;
    logic [7:0] src_row;
    logic [7:0] src_col;

    assign col     = clamp_coord(x, c, sw);
    assign row     = clamp_coord(y, r, sh);
    assign src_row = {1'b0, v0} + {3'b000, row};
    assign src_col = {1'b0, h0} + {3'b000, col};
    assign addr    = mul_pitch(src_row) + {{(ROM_AW-8){1'b0}}, src_col};

endmodule

// File: rtl/bicubic_win_fetch.sv
// 4x4 window fetch with border clamping and a one-window cache (hit / +1 step / miss).
module bicubic_win_fetch #(
    parameter int IMG_W  = bicubic_pkg::IMG_W,
    parameter int PIX_W  = bicubic_pkg::PIX_W,
    parameter int ROM_AW = bicubic_pkg::ROM_AW
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [6:0]          H0,
    input  logic [6:0]          V0,
    input  logic [4:0]          SW,
    input  logic [4:0]          SH,
    input  logic                frame_start,
    bicubic_win_fetch_if.slave  bus
);
    import bicubic_pkg::*;

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic              ready;
    logic              ce;
    logic              wvalid;
    logic              accept;
    logic              is_hit;
    logic              is_step;
    logic              last_rd;
    logic              cache_vld;
    logic              fs_seen;
    logic              step_mode;
    logic [3:0]        rd_cnt;
    logic [1:0]        rd_col;
    logic [1:0]        rd_row;
    logic [4:0]        cur_x;
    logic [4:0]        cur_y;
    logic [ROM_AW-1:0] gen_addr;
    logic              vld_p0;
    logic [3:0]        slot_p0;
    logic [PIX_W-1:0]  win_q [16];

    assign accept  = ready && bus.req_valid;
    assign is_hit  = cache_vld && !frame_start &&
                     (bus.req_x == cur_x) && (bus.req_y == cur_y);
    assign is_step = cache_vld && !frame_start && (bus.req_y == cur_y) &&
                     ({1'b0, bus.req_x} == ({1'b0, cur_x} + 6'd1));

    // A step re-reads only column 3; a miss walks all 16 column-major.
    assign rd_col  = step_mode ? 2'd3 : rd_cnt[3:2];
    assign rd_row  = rd_cnt[1:0];
    assign last_rd = (rd_row == 2'd3) && (step_mode || (rd_cnt[3:2] == 2'd3));

    bicubic_addr_gen #(
        .IMG_W  (IMG_W),
        .ROM_AW (ROM_AW)
    ) u_addr_gen (
        .h0   (H0),
        .v0   (V0),
        .sw   (SW),
        .sh   (SH),
        .x    (cur_x),
        .y    (cur_y),
        .c    (rd_col),
        .r    (rd_row),
        .addr (gen_addr)
    );

    always_ff @(posedge CLK) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        ce        = 1'b0;
        wvalid    = 1'b0;
        unique case (state)
            IDLE: begin
                ready = !RST;
                if (bus.req_valid && !RST)
                    state_nxt = is_hit ? OUT : FETCH;
            end
            FETCH: begin
                ce = 1'b1;
                if (last_rd)
                    state_nxt = DRAIN;
            end
            DRAIN: state_nxt = OUT;
            OUT: begin
                wvalid = 1'b1;
                if (bus.win_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // fs_seen remembers a frame_start that arrived mid-fetch so DRAIN leaves the cache invalid.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cache_vld <= 1'b0;
            fs_seen   <= 1'b0;
            step_mode <= 1'b0;
            rd_cnt    <= '0;
            vld_p0    <= 1'b0;
        end else begin
            vld_p0 <= ce;
            if (accept) begin
                rd_cnt    <= '0;
                step_mode <= is_step;
                fs_seen   <= 1'b0;
            end else if (state == FETCH) begin
                rd_cnt <= rd_cnt + 4'd1;
                if (frame_start)
                    fs_seen <= 1'b1;
            end
            if (frame_start)
                cache_vld <= 1'b0;
            else if (state == DRAIN)
                cache_vld <= !fs_seen;
        end
    end

    // ---- p0: slot of the read in flight; ROM data lands one cycle later ----
    always_ff @(posedge CLK) begin
        slot_p0 <= {rd_row, rd_col};
        if (accept) begin
            cur_x <= bus.req_x;
            cur_y <= bus.req_y;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 16; i++)
                win_q[i] <= '0;
        end else if (accept && is_step) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 3; c++)
                    win_q[4*r+c] <= win_q[4*r+c+1];
        end else if (vld_p0) begin
            win_q[slot_p0] <= bus.rom_q;
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_pack
        assign bus.win_data[i*PIX_W +: PIX_W] = win_q[i];
    end

    assign bus.req_ready = ready;
    assign bus.rom_ce    = ce;
    assign bus.rom_addr  = ce ? gen_addr : '0;
    assign bus.win_valid = wvalid;

endmodule

// File: doc/bicubic_win_fetch.md
# bicubic_win_fetch

Window-fetch stage directly upstream of the bicubic interpolation datapath inside `Bicubic`. It takes an integer source coordinate inside the ROI, reads the 4x4 neighbourhood from the 100x100 image ROM with border clamping, and hands the 16 pixels to the interpolator over a valid/ready handshake. A 4-column window register skips reads on repeated requests and re-reads only one column on +1 horizontal steps.

## Interface
- `IMG_W`, default 100, source image row pitch in pixels.
- `PIX_W`, default 8, pixel width in bits.
- `ROM_AW`, default 14, ROM address width.
- `CLK`  in  1  clock; all logic on the rising edge.
- `RST`  in  1  synchronous reset, active-high.
- `H0`, `V0`  in  7 each  ROI origin column and row; stable while `frame_start`=0.
- `SW`, `SH`  in  5 each  ROI width and height, each ≥1.
- `frame_start`  in  1  one-cycle pulse; invalidates the window cache.
- `req_valid`  in  1  request present.
- `req_x`, `req_y`  in  5 each  base coordinate, ROI-relative; `req_x`<`SW`, `req_y`<`SH`.
- `req_ready`  out  1  request accepted when both valid and ready are high.
- `rom_ce`  out  1  ROM read enable.
- `rom_addr`  out  ROM_AW  ROM address; data returns one cycle later.
- `rom_q`  in  PIX_W  ROM read data.
- `win_valid`  out  1  window output valid.
- `win_ready`  in  1  consumer accepts the window.
- `win_data`  out  16*PIX_W  byte `4*r+c` holds the pixel at ROI (`req_y`-1+r, `req_x`-1+c), r and c in 0..3.

## Operation
- States: IDLE, FETCH, DRAIN, OUT.
- IDLE: `req_ready`=1. On acceptance, latch x and y, then classify the request:
  - HIT: cache valid and x, y both equal the last values. Go to OUT with no reads.
  - STEP: cache valid, same y, and x = last x + 1. Shift the window left by one column, then fetch only column c=3 (4 reads).
  - MISS: any other case. Fetch all columns c=0..3 (16 reads).
- FETCH: one read per cycle, column-major, r=0..3 within each column.
  - Clamping: col = clamp(x-1+c, 0, SW-1) and row = clamp(y-1+r, 0, SH-1), computed in 7-bit signed arithmetic.
  - Address: `rom_addr` = (V0+row)*IMG_W + (H0+col), computed without a multiplier (e.g. 64+32+4 shifts).
  - After the last read, go to DRAIN.
- DRAIN: capture the last `rom_q`, set the cache valid, go to OUT. Every `rom_q` is captured exactly one cycle after its address.
- OUT: `win_valid`=1. Data holds stable until `win_ready`; return to IDLE on the handshake cycle.
- `frame_start` clears the cache-valid bit in any state, and the next request is a MISS.
  - If `frame_start` coincides with a request acceptance, the request is treated as a MISS.
  - A `frame_start` during FETCH lets the fetch complete but leaves the cache invalid afterwards.
- Reset values: state=IDLE, cache invalid, `req_ready`=0 during reset then 1, `rom_ce`=0, `rom_addr`=0, `win_valid`=0, `win_data`=0.
- Reset in any state aborts the operation. `rom_ce` is low in the cycle after reset is sampled.

## Timing
- Request accepted at edge T.
- MISS: `rom_ce`=1 in cycles T+1..T+16, DRAIN at T+17, `win_valid` from T+18.
- STEP: `rom_ce`=1 in cycles T+1..T+4, `win_valid` from T+6.
- HIT: `win_valid` from T+1.
- Throughput: `req_ready` returns one cycle after the `win_valid`&`win_ready` handshake.
- `rom_ce`=0 outside FETCH.

## Structure
- Shared package `bicubic_pkg` holds `IMG_W`, `PIX_W`, `ROM_AW`, the `fetch_state_t` enum (IDLE, FETCH, DRAIN, OUT), and the window typedef `win_t` (16 pixels).
- Sub-module `bicubic_addr_gen` is combinational: it does the clamp and the row*IMG_W+col address calculation. It is reused by the result-address logic.
- Top-level contents: FSM, read counter (4 bits), capture pipeline register, 4x4 window shift register.

## Test plan
- ROM holds mem[a]=a[7:0]; H0=10, V0=20, SW=8, SH=8; request (3,3).
  - Required: 16 reads with the first address 2212, `win_valid` at T+18, `win_data` byte0 = 0xA4.
- Next request (4,3).
  - Required: exactly 4 reads at addresses 2216, 2316, 2416, 2516, `win_valid` at T+6, bytes 0..2 of each row equal to bytes 1..3 of that row in the previous window.
- Repeat request (4,3).
  - Required: `rom_ce` stays 0, `win_valid` at T+1, identical `win_data`.
- Request (0,0) after `frame_start`.
  - Required: MISS; rows 0 and 1 of the window are identical, columns 0 and 1 are identical; byte0 = mem[2010].
  - Request (7,7): the clamped last row and column both use row/col 7, giving address 2717.
- Hold `win_ready`=0 for 5 cycles in OUT.
  - Required: `win_valid` and `win_data` stable, `req_ready`=0, `rom_ce`=0.
- Assert `RST` in the 6th FETCH cycle.
  - Required: `rom_ce`=0 on the next cycle, `win_valid` never asserts; re-issuing (4,3) then performs a full 16-read MISS.
